// File: rtl/pcoeff_top_accumulator.sv
// pcoeff_top_accumulator
//
// Consumer side of the full-permutation pipeline. Per-bot result words are
// summed into per-top totals, and one totals record is emitted per top.
//
// The block snoops the pipeline input handshake and keeps an in-order FIFO of
// startNewTop tags. This tells it which result opens a new top. One tag is
// popped for every accepted result.
//
// Ports
//   clock, rst          sole clock; synchronous active-high reset
//   tagValid            a bot entered the pipeline this cycle
//   tagStartNewTop      startNewTop flag of that bot
//   tagAlmostFull       registered; upstream must stop issuing bots
//   resultValid/Ready   result stream handshake (pipeline ovalid / iready)
//   resultData[63:0]    [63] ECC error, [60:48] pcoeff count, [47:0] sum
//   flush               single-cycle pulse: close the open top once drained
//   topValid/Ready      totals record handshake
//   topSum, topPcoeffCount, topBotCount, topEccError   totals record
//   errTagOverflow      sticky: a tag was dropped because the FIFO was full
//   errOrphanResult     sticky: a result opened a top without a start tag
module pcoeff_top_accumulator #(
  parameter int TAG_FIFO_DEPTH     = 1024,
  parameter int ALMOST_FULL_MARGIN = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        tagValid,
  input  logic        tagStartNewTop,
  output logic        tagAlmostFull,
  input  logic        resultValid,
  output logic        resultReady,
  input  logic [63:0] resultData,
  input  logic        flush,
  output logic        topValid,
  input  logic        topReady,
  output logic [63:0] topSum,
  output logic [31:0] topPcoeffCount,
  output logic [31:0] topBotCount,
  output logic        topEccError,
  output logic        errTagOverflow,
  output logic        errOrphanResult
);

  localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL        = CNT_W'(TAG_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_FULL_LEVEL = CNT_W'(TAG_FIFO_DEPTH - ALMOST_FULL_MARGIN);

  // Tag FIFO
  logic             tagMem [TAG_FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] rdPtrNext;
  logic [CNT_W-1:0] tagCount;
  logic [CNT_W-1:0] tagCountNext;
  logic             headTag;
  logic             fifoNotEmpty;
  logic             fifoFull;
  logic             fifoLastEntry;
  logic             tagPush;
  logic             tagPop;
  logic             tagDrop;

  // Accumulation / output state
  logic        topOpen;
  logic        outFull;
  logic        flushPending;
  logic [63:0] accSum;
  logic [31:0] accPcoeff;
  logic [31:0] accBots;
  logic        accEcc;
  logic [63:0] holdSum;
  logic [31:0] holdPcoeff;
  logic [31:0] holdBots;
  logic        holdEcc;

  // Per-cycle control
  logic        closeTop;
  logic        accept;
  logic        flushExec;
  logic        topHandshake;
  logic        loadHold;
  logic [63:0] botSum;
  logic [31:0] botPcoeff;
  logic        botEcc;
  logic        unusedBits;

  assign botSum     = {16'd0, resultData[47:0]};
  assign botPcoeff  = {19'd0, resultData[60:48]};
  assign botEcc     = resultData[63];
  assign unusedBits = ^resultData[62:61];

  // ---------------------------------------------------------------------------
  // Tag FIFO: the head entry lives in a registered read port.
  // The FIFO is first-word-fall-through. Each cycle the port is loaded with the
  // entry that becomes the head after this cycle's pop.
  // A tag pushed into that same slot is bypassed into the port. As a result, a
  // push into an empty FIFO is visible at the head on the very next cycle.
  // ---------------------------------------------------------------------------
  assign fifoNotEmpty  = (tagCount != '0);
  assign fifoFull      = (tagCount == FULL_LEVEL);
  assign fifoLastEntry = (tagCount == CNT_W'(1));
  assign tagPop        = accept;
  // When the FIFO is full, a push is still taken if a pop frees a slot in the
  // same cycle.
  assign tagPush       = tagValid & (~fifoFull | tagPop);
  assign tagDrop       = tagValid & fifoFull & ~tagPop;
  assign rdPtrNext     = tagPop ? rdPtr + PTR_W'(1) : rdPtr;

  always_comb begin
    tagCountNext = tagCount;
    case ({tagPush, tagPop})
      2'b10:   tagCountNext = tagCount + CNT_W'(1);
      2'b01:   tagCountNext = tagCount - CNT_W'(1);
      default: tagCountNext = tagCount;
    endcase
  end

  always_ff @(posedge clock) begin
    if (tagPush) begin
      tagMem[wrPtr] <= tagStartNewTop;
    end
    if (tagPush && (wrPtr == rdPtrNext)) begin
      headTag <= tagStartNewTop;
    end else begin
      headTag <= tagMem[rdPtrNext];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      tagCount      <= '0;
      tagAlmostFull <= 1'b0;
    end else begin
      if (tagPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      rdPtr         <= rdPtrNext;
      tagCount      <= tagCountNext;
      tagAlmostFull <= (tagCountNext >= ALMOST_FULL_LEVEL);
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake control. resultReady depends only on registered state and on rst.
  // A result is refused whenever accepting it would need the holding register
  // while that register is still occupied. Two cases need it:
  //   - the result closes the open top;
  //   - the result is the last one queued and a flush is waiting behind it.
  // ---------------------------------------------------------------------------
  assign closeTop     = headTag & topOpen;
  assign resultReady  = ~rst & fifoNotEmpty
                      & ~(outFull & closeTop)
                      & ~(outFull & flushPending & fifoLastEntry);
  assign accept       = resultValid & resultReady;
  assign flushExec    = flushPending & ~fifoNotEmpty & ~accept & ~outFull;
  assign topHandshake = outFull & topReady;
  assign loadHold     = (accept & closeTop) | (flushExec & topOpen);

  always_ff @(posedge clock) begin
    if (rst) begin
      topOpen         <= 1'b0;
      flushPending    <= 1'b0;
      outFull         <= 1'b0;
      accSum          <= '0;
      accPcoeff       <= '0;
      accBots         <= '0;
      accEcc          <= 1'b0;
      holdSum         <= '0;
      holdPcoeff      <= '0;
      holdBots        <= '0;
      holdEcc         <= 1'b0;
      errTagOverflow  <= 1'b0;
      errOrphanResult <= 1'b0;
    end else begin
      // The holding register may reload in the same cycle that the
      // downstream side takes the previous record.
      if (loadHold) begin
        outFull    <= 1'b1;
        holdSum    <= accSum;
        holdPcoeff <= accPcoeff;
        holdBots   <= accBots;
        holdEcc    <= accEcc;
      end else if (topHandshake) begin
        outFull <= 1'b0;
      end

      if (accept) begin
        topOpen <= 1'b1;
        if (closeTop || !topOpen) begin
          accSum    <= botSum;
          accPcoeff <= botPcoeff;
          accBots   <= 32'd1;
          accEcc    <= botEcc;
        end else begin
          accSum    <= accSum + botSum;
          accPcoeff <= accPcoeff + botPcoeff;
          accBots   <= accBots + 32'd1;
          accEcc    <= accEcc | botEcc;
        end
        if (!topOpen && !headTag) begin
          errOrphanResult <= 1'b1;
        end
      end else if (flushExec) begin
        topOpen <= 1'b0;
      end

      // A flush that arrives while another is pending merges into it.
      if (flushExec) begin
        flushPending <= 1'b0;
      end else if (flush) begin
        flushPending <= 1'b1;
      end

      if (tagDrop) begin
        errTagOverflow <= 1'b1;
      end
    end
  end

  assign topValid       = outFull;
  assign topSum         = holdSum;
  assign topPcoeffCount = holdPcoeff;
  assign topBotCount    = holdBots;
  assign topEccError    = holdEcc;

endmodule

// File: tb/tb_pcoeff_top_accumulator.sv
// Testbench for pcoeff_top_accumulator.
// The bench plays the pipeline role. Bots queued for issue have their tags
// pushed when tagAlmostFull allows. Their result words become presentable
// from the following cycle, in order.
// A reference model tracks the tag queue, the open top and its running
// totals, and the records expected downstream, all from the block's rules.
module tb_pcoeff_top_accumulator;

  localparam int DEPTH    = 1024;
  localparam int MARGIN   = 16;
  localparam int AF_LEVEL = DEPTH - MARGIN;

  typedef struct packed {
    logic [63:0] sum;
    logic [31:0] pc;
    logic [31:0] bots;
    logic        ecc;
  } TopRec;

  typedef struct packed {
    logic        tag;
    logic [63:0] data;
  } Bot;

  logic        clock = 1'b0;
  logic        rst;
  logic        tagValid;
  logic        tagStartNewTop;
  logic        tagAlmostFull;
  logic        resultValid;
  logic        resultReady;
  logic [63:0] resultData;
  logic        flush;
  logic        topValid;
  logic        topReady;
  logic [63:0] topSum;
  logic [31:0] topPcoeffCount;
  logic [31:0] topBotCount;
  logic        topEccError;
  logic        errTagOverflow;
  logic        errOrphanResult;

  pcoeff_top_accumulator #(
    .TAG_FIFO_DEPTH    (DEPTH),
    .ALMOST_FULL_MARGIN(MARGIN)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .tagValid       (tagValid),
    .tagStartNewTop (tagStartNewTop),
    .tagAlmostFull  (tagAlmostFull),
    .resultValid    (resultValid),
    .resultReady    (resultReady),
    .resultData     (resultData),
    .flush          (flush),
    .topValid       (topValid),
    .topReady       (topReady),
    .topSum         (topSum),
    .topPcoeffCount (topPcoeffCount),
    .topBotCount    (topBotCount),
    .topEccError    (topEccError),
    .errTagOverflow (errTagOverflow),
    .errOrphanResult(errOrphanResult)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Stimulus state
  Bot          issueQ[$];
  logic [63:0] pendQ[$];
  int          validPct = 100;
  int          readyPct = 100;
  bit          manualTags = 0;
  bit          forceValid = 0;
  bit          issuedNow = 0;

  // Reference model
  bit    tagQ[$];
  TopRec expQ[$];
  TopRec accM;
  TopRec lastRec;
  bit    openM = 0;
  bit    flushM = 0;
  bit    orphanM = 0;
  bit    overflowM = 0;
  int    recCount = 0;
  int    acceptCount = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic addBot(input bit tag, input logic [47:0] sum, input logic [12:0] pc,
                        input bit ecc, input logic [1:0] junk);
    Bot b;
    b.tag  = tag;
    b.data = {ecc, junk, pc, sum};
    issueQ.push_back(b);
  endtask

  task automatic drive();
    issuedNow = 0;
    if (!manualTags) begin
      tagValid       = 1'b0;
      tagStartNewTop = 1'b0;
      if (issueQ.size() > 0 && !tagAlmostFull) begin
        tagValid       = 1'b1;
        tagStartNewTop = issueQ[0].tag;
        issuedNow      = 1;
      end
    end
    resultValid = 1'b0;
    resultData  = 64'd0;
    if (pendQ.size() > 0 && int'($urandom_range(99)) < validPct) begin
      resultValid = 1'b1;
      resultData  = pendQ[0];
    end else if (forceValid) begin
      resultValid = 1'b1;
      resultData  = 64'h7B;
    end
    topReady = (int'($urandom_range(99)) < readyPct);
  endtask

  // One clock cycle. Inputs are driven at the negedge, and outputs are
  // sampled 1 time unit later. The model is stepped to mirror the coming edge.
  task automatic tick(input bit doFlush);
    TopRec       r;
    Bot          b;
    logic [63:0] d;
    bit          t;
    bit          expReady;
    drive();
    flush = doFlush;
    #1;
    if (!rst) begin
      check("errOrphanResult", errOrphanResult, orphanM);
      check("errTagOverflow", errTagOverflow, overflowM);
      expReady = (tagQ.size() > 0) &&
                 !((expQ.size() > 0) && ((tagQ[0] && openM) || (flushM && tagQ.size() == 1)));
      check("resultReady", resultReady, expReady);
      check("tagAlmostFull", tagAlmostFull, tagQ.size() >= AF_LEVEL);

      if (topValid && topReady) begin
        check("recordExpected", topValid, expQ.size() > 0);
        if (expQ.size() > 0) begin
          r = expQ.pop_front();
          check("topSum", topSum, r.sum);
          check("topPcoeffCount", topPcoeffCount, r.pc);
          check("topBotCount", topBotCount, r.bots);
          check("topEccError", topEccError, r.ecc);
          lastRec.sum  = topSum;
          lastRec.pc   = topPcoeffCount;
          lastRec.bots = topBotCount;
          lastRec.ecc  = topEccError;
          recCount++;
          $display("record %0d sum=%0h pcoeff=%0d bots=%0d ecc=%0b",
                   recCount, topSum, topPcoeffCount, topBotCount, topEccError);
        end
      end

      if (resultValid && resultReady) begin
        if (tagQ.size() == 0) begin
          check("acceptWhileEmpty", resultReady, 0);
        end else begin
          t = tagQ.pop_front();
          d = resultData;
          if (pendQ.size() > 0) void'(pendQ.pop_front());
          acceptCount++;
          r.sum  = {16'd0, d[47:0]};
          r.pc   = {19'd0, d[60:48]};
          r.bots = 32'd1;
          r.ecc  = d[63];
          if (!openM) begin
            openM = 1;
            accM  = r;
            if (!t) orphanM = 1;
          end else if (t) begin
            expQ.push_back(accM);
            accM = r;
          end else begin
            accM.sum  = accM.sum + r.sum;
            accM.pc   = accM.pc + r.pc;
            accM.bots = accM.bots + 32'd1;
            accM.ecc  = accM.ecc | r.ecc;
          end
        end
      end

      if (tagValid) begin
        if (tagQ.size() < DEPTH) tagQ.push_back(tagStartNewTop);
        else overflowM = 1;
        if (issuedNow) begin
          b = issueQ.pop_front();
          pendQ.push_back(b.data);
        end
      end

      if (doFlush) flushM = 1;
      if (flushM && tagQ.size() == 0) begin
        if (openM) expQ.push_back(accM);
        openM  = 0;
        flushM = 0;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    rst            = 1'b1;
    tagValid       = 1'b0;
    tagStartNewTop = 1'b0;
    resultValid    = 1'b0;
    resultData     = 64'd0;
    flush          = 1'b0;
    topReady       = 1'b0;
    manualTags     = 0;
    forceValid     = 0;
    #1;
    check("resetCycleReady", resultReady, 0);
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    issueQ.delete();
    pendQ.delete();
    tagQ.delete();
    expQ.delete();
    openM     = 0;
    flushM    = 0;
    orphanM   = 0;
    overflowM = 0;
    #1;
    check("resetFlags", {topValid, topEccError, errTagOverflow, errOrphanResult,
                         tagAlmostFull, resultReady}, 0);
    check("resetTopSum", topSum, 0);
    check("resetTopPcoeff", topPcoeffCount, 0);
    check("resetTopBots", topBotCount, 0);
  endtask

  task automatic runIssue(input int budget);
    int n = 0;
    while (issueQ.size() > 0 && n < budget) begin
      tick(0);
      n++;
    end
    check("issueTimeout", issueQ.size(), 0);
  endtask

  task automatic drainAll(input int budget);
    int n = 0;
    validPct = 100;
    readyPct = 100;
    while ((issueQ.size() > 0 || pendQ.size() > 0 || expQ.size() > 0 || flushM) && n < budget) begin
      tick(0);
      n++;
    end
    check("drainTimeout", issueQ.size() + pendQ.size() + expQ.size(), 0);
    repeat (3) tick(0);
  endtask

  task automatic basicStream();
    for (int i = 1; i <= 7; i++) begin
      addBot((i == 1) || (i == 5) || (i == 7), 48'(i), 13'(i * 10), 1'b0, 2'b00);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int a0;
    int n;
    logic [63:0] rnd;

    doReset();

    // Basic totals over three tops
    validPct = 100;
    readyPct = 100;
    r0 = recCount;
    basicStream();
    runIssue(50);
    tick(1);
    drainAll(200);
    check("basicRecordCount", recCount - r0, 3);
    check("basicLastSum", lastRec.sum, 7);
    check("basicLastPcoeff", lastRec.pc, 70);

    // Downstream backpressure
    doReset();
    r0 = recCount;
    validPct = 100;
    readyPct = 0;
    basicStream();
    runIssue(50);
    tick(1);
    n = 0;
    while (!topValid && n < 40) begin
      tick(0);
      n++;
    end
    check("bpFirstValid", topValid, 1);
    repeat (50) tick(0);
    check("bpHoldValid", topValid, 1);
    check("bpHoldSum", topSum, 10);
    check("bpHoldPcoeff", topPcoeffCount, 100);
    check("bpHoldBots", topBotCount, 4);
    check("bpStall", resultReady, 0);
    drainAll(200);
    check("bpRecordCount", recCount - r0, 3);

    // Empty FIFO: valid without tags is never accepted
    doReset();
    forceValid = 1;
    repeat (5) tick(0);
    a0 = acceptCount;
    addBot(1'b1, 48'd42, 13'd3, 1'b0, 2'b00);
    tick(0);
    tick(0);
    check("emptyFirstAccept", acceptCount - a0, 1);
    forceValid = 0;
    tick(1);
    drainAll(100);
    check("emptyRecordSum", lastRec.sum, 42);

    // ECC propagation and 48-bit sums carried into 64-bit totals
    doReset();
    addBot(1'b1, 48'd5, 13'd1, 1'b0, 2'b00);
    addBot(1'b0, 48'hFFFF_FFFF_FFFF, 13'd2, 1'b1, 2'b11);
    addBot(1'b0, 48'hFFFF_FFFF_FFFF, 13'd3, 1'b0, 2'b10);
    addBot(1'b0, 48'd3, 13'h1FFF, 1'b0, 2'b01);
    runIssue(50);
    tick(1);
    drainAll(100);
    check("eccSum", lastRec.sum, 64'h2_0000_0000_0006);
    check("eccPcoeff", lastRec.pc, 32'h2005);
    check("eccFlag", lastRec.ecc, 1);

    // Orphan result: first result carries tag 0
    doReset();
    r0 = recCount;
    addBot(1'b0, 48'd1, 13'd1, 1'b0, 2'b00);
    addBot(1'b0, 48'd2, 13'd2, 1'b0, 2'b00);
    runIssue(50);
    tick(1);
    drainAll(100);
    check("orphanFlag", errOrphanResult, 1);
    check("orphanRecordCount", recCount - r0, 1);
    check("orphanBots", lastRec.bots, 2);

    // Tag FIFO overflow and almost-full threshold
    doReset();
    manualTags = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      tagValid       = 1'b1;
      tagStartNewTop = 1'($urandom_range(1));
      tick(0);
    end
    tagValid   = 1'b0;
    manualTags = 0;
    tick(0);
    check("ovfAlmostFull", tagAlmostFull, 1);
    check("ovfFlag", errTagOverflow, 1);

    // Reset in the middle of an open top
    doReset();
    a0 = acceptCount;
    r0 = recCount;
    addBot(1'b1, 48'd9, 13'd9, 1'b0, 2'b00);
    addBot(1'b0, 48'd9, 13'd9, 1'b0, 2'b00);
    addBot(1'b0, 48'd9, 13'd9, 1'b0, 2'b00);
    n = 0;
    while (acceptCount - a0 < 3 && n < 30) begin
      tick(0);
      n++;
    end
    check("midResetAccepts", acceptCount - a0, 3);
    doReset();
    readyPct = 100;
    repeat (10) tick(0);
    check("midResetNoRecord", recCount - r0, 0);
    addBot(1'b1, 48'd1, 13'd1, 1'b0, 2'b00);
    addBot(1'b0, 48'd2, 13'd2, 1'b0, 2'b00);
    runIssue(50);
    tick(1);
    drainAll(100);
    check("midResetFreshBots", lastRec.bots, 2);

    // Randomized traffic
    doReset();
    for (int round = 0; round < 6; round++) begin
      validPct = 30 + int'($urandom_range(70));
      readyPct = 20 + int'($urandom_range(80));
      for (int tp = 0; tp < 3 + int'($urandom_range(5)); tp++) begin
        for (int bt = 0; bt < 1 + int'($urandom_range(5)); bt++) begin
          rnd = {$urandom(), $urandom()};
          addBot(bt == 0, rnd[47:0], 13'($urandom()), ($urandom_range(7) == 0),
                 2'($urandom()));
        end
      end
      runIssue(2000);
      tick(1);
      drainAll(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
